// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path: op codes, sequencer states
// and digit blanking masks (bit n set = digit n dark).
package calc_pkg;

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_SAVE = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_MUL  = 3'd4;
   localparam logic [2:0] OP_DIV  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SHOW_OP  = 2'd1,
      ST_WAIT_RES = 2'd2,
      ST_SHOW_RES = 2'd3
   } state_t;

   localparam logic [3:0] BLANK_NONE = 4'b0000;
   localparam logic [3:0] BLANK_ALL  = 4'b1111;
   localparam logic [3:0] BLANK_TOP  = 4'b1000;

   function automatic logic op_valid(input logic [2:0] op);
      case (op)
         OP_SAVE, OP_ADD, OP_SUB, OP_MUL, OP_DIV: return 1'b1;
         default:                                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/digit_scan.sv
// Digit scan timebase: each of the 4 digits is selected for SCAN_DIV cycles in turn.
// Free-running from reset; an_pat is the active-low anode pattern for idx (combinational).
module digit_scan #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] idx,
   output logic [3:0] an_pat
);

   localparam int CW = $clog2(SCAN_DIV);

   logic [CW-1:0] scan_cnt;
   logic          scan_wrap;

   assign scan_wrap = (scan_cnt == CW'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
      end else if (scan_wrap) begin
         scan_cnt <= '0;
         idx      <= idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign an_pat = ~(4'b0001 << idx);

endmodule

// File: rtl/calc_display_ctrl.sv
// Display sequencer: shows the op mnemonic for HOLD_CYCLES after a strobe, then the ALU result.
// AN/DIGIT are registered (1 cycle behind state/idx); no backpressure, inputs are pulses.
module calc_display_ctrl
   import calc_pkg::*;
#(
   parameter int SCAN_DIV    = 50000,
   parameter int HOLD_CYCLES = 100000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  op_sel,
   input  logic        op_strobe,
   input  logic [15:0] result,
   input  logic        result_valid,
   input  logic [15:0] mnemonic,
   output logic [2:0]  op_code,
   output logic [3:0]  digit,
   output logic [3:0]  an,
   output logic        busy
);

   localparam int HW = $clog2(HOLD_CYCLES);

   state_t        state, state_nxt;
   logic [HW-1:0] hold_cnt;
   logic          hold_done;
   logic [15:0]   res_reg;
   logic          pending;
   logic [1:0]    idx;
   logic [3:0]    an_pat;
   logic [15:0]   src;
   logic [3:0]    blank;
   logic [3:0]    an_nxt;
   logic [3:0]    digit_nxt;

   digit_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
      .clk    (clk),
      .rst    (rst),
      .idx    (idx),
      .an_pat (an_pat)
   );

   assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         op_code  <= OP_NONE;
         hold_cnt <= '0;
         res_reg  <= 16'h0000;
         pending  <= 1'b0;
         an       <= BLANK_ALL;
         digit    <= 4'h0;
      end else begin
         state <= state_nxt;
         an    <= an_nxt;
         digit <= digit_nxt;
         if (result_valid) begin
            res_reg <= result;
            pending <= 1'b1;
         end
         // a strobe overrides pending, but a same-cycle result stays latched
         if (op_strobe) begin
            hold_cnt <= '0;
            if (op_valid(op_sel)) begin
               op_code <= op_sel;
               pending <= result_valid;
            end else begin
               op_code <= OP_NONE;
               pending <= 1'b0;
            end
         end else if (state == ST_SHOW_OP && !hold_done) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (op_strobe) begin
         state_nxt = op_valid(op_sel) ? ST_SHOW_OP : ST_IDLE;
      end else begin
         case (state)
            ST_SHOW_OP: begin
               // a result arriving on the final hold cycle must not be stranded in WAIT_RES
               if (hold_done)
                  state_nxt = (pending || result_valid) ? ST_SHOW_RES : ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
               if (result_valid) state_nxt = ST_SHOW_RES;
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      src   = mnemonic;
      blank = BLANK_NONE;
      case (state)
         ST_IDLE:     blank = BLANK_ALL;
         ST_SHOW_OP,
         ST_WAIT_RES: blank = (op_code == OP_SAVE) ? BLANK_NONE : BLANK_TOP;
         ST_SHOW_RES: src   = res_reg;
         default:     blank = BLANK_ALL;
      endcase
      an_nxt    = blank[idx] ? 4'b1111 : an_pat;
      digit_nxt = blank[idx] ? 4'h0 : src[{idx, 2'b00} +: 4];
   end

   assign busy = (state == ST_SHOW_OP) || (state == ST_WAIT_RES);

endmodule
